// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 8-opcode MIPS-subset CPU.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_control #(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned WAIT_MAX = 16
`ifdef CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          alu_op,
  output logic                jump,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic                sign_or_zero,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic                mem_timeout
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  localparam int unsigned WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_SLI  = 3'd1;
  localparam logic [2:0] OP_J    = 3'd2;
  localparam logic [2:0] OP_JAL  = 3'd3;
  localparam logic [2:0] OP_LW   = 3'd4;
  localparam logic [2:0] OP_SW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } st_t;

  st_t               cur_st;
  st_t               nxt_st;
  logic [2:0]        op_q;
  logic [2:0]        dec_op;
  logic              upper_nz;
  logic [WCNT_W-1:0] wait_cnt;
  logic              expire;
  logic              timeout_c;

  assign dec_op   = opcode[2:0];
  assign upper_nz = |(opcode >> 3);
  assign state    = cur_st;
  // Expiry is the WAIT_MAX-th waiting cycle; a ready in that same cycle still completes.
  assign expire   = (WAIT_MAX != 0) && (wait_cnt == WCNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_st      <= ST_FETCH;
      op_q        <= 3'd0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      if (cur_st == ST_DECODE) op_q <= dec_op;
      if (timeout_c) mem_timeout <= 1'b1;
      if (timeout_c || (nxt_st != cur_st)) begin
        wait_cnt <= '0;
      end else if ((WAIT_MAX != 0) && ((cur_st == ST_FETCH) || (cur_st == ST_MEM))) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
    end
  end

  // Next state and Moore controls; everything is held at its idle value while reset is high.
  always_comb begin
    nxt_st       = cur_st;
    timeout_c    = 1'b0;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_dst      = 2'b00;
    mem_to_reg   = 2'b00;
    alu_op       = 2'b00;
    jump         = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    sign_or_zero = 1'b1;
    illegal_op   = 1'b0;
    if (!reset) begin
      unique case (cur_st)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt_st   = ST_DECODE;
          end else if (expire) begin
            timeout_c = 1'b1;
          end
        end
        ST_DECODE: begin
          if (upper_nz) begin
            illegal_op = 1'b1;
            nxt_st     = ST_FETCH;
          end else begin
            case (dec_op)
              OP_J: begin
                jump     = 1'b1;
                pc_write = 1'b1;
                nxt_st   = ST_FETCH;
              end
              OP_JAL: begin
                jump       = 1'b1;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                nxt_st     = ST_FETCH;
              end
              default: nxt_st = ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_SLI: begin
              alu_op       = 2'b10;
              alu_src      = 1'b1;
              sign_or_zero = 1'b0;
              nxt_st       = ST_WB;
            end
            OP_LW, OP_SW: begin
              alu_op  = 2'b11;
              alu_src = 1'b1;
              nxt_st  = ST_MEM;
            end
            OP_ADDI: begin
              alu_op  = 2'b11;
              alu_src = 1'b1;
              nxt_st  = ST_WB;
            end
            OP_BEQ: begin
              alu_op = 2'b01;
              branch = 1'b1;
              nxt_st = ST_FETCH;
            end
            default: nxt_st = ST_WB;
          endcase
        end
        ST_MEM: begin
          if (op_q == OP_SW) mem_write = 1'b1;
          else               mem_read  = 1'b1;
          if (dmem_ready) begin
            nxt_st = (op_q == OP_SW) ? ST_FETCH : ST_WB;
          end else if (expire) begin
            timeout_c = 1'b1;
            nxt_st    = ST_FETCH;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          if (op_q == OP_R)  reg_dst    = 2'b01;
          if (op_q == OP_LW) mem_to_reg = 2'b01;
          nxt_st = ST_FETCH;
        end
        default: nxt_st = ST_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic instr_done;

  // A completed instruction is any return to FETCH other than an illegal decode or a timeout.
  assign instr_done = (nxt_st == ST_FETCH) && (cur_st != ST_FETCH) && !illegal_op && !timeout_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written corner sequences and
// randomized stimulus against a phase-route reference model.
module tb_multicycle_control;

  localparam int OPW  = 6;
  localparam int WMAX = 4;

  localparam int PH_F = 0;
  localparam int PH_D = 1;
  localparam int PH_E = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       sign_or_zero;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    logic [OPW-1:0] opc;
    logic           ir;
    logic           dr;
    ctl_t           exp;
    bit             fetch;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [OPW-1:0] opcode = '0;
  logic           imem_ready = 1'b0;
  logic           dmem_ready = 1'b0;
  logic           imem_req, ir_write, pc_write;
  logic [1:0]     reg_dst, mem_to_reg, alu_op;
  logic           jump, branch, mem_read, mem_write, alu_src, reg_write, sign_or_zero;
  logic [2:0]     state;
  logic           illegal_op, mem_timeout;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]    cycle_cnt, instr_cnt;
`endif

  multicycle_control #(.OPCODE_W(OPW), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .jump(jump), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .sign_or_zero(sign_or_zero),
    .state(state), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  ctl_t dut_ctl;
  assign dut_ctl = {imem_req, ir_write, pc_write, reg_dst, mem_to_reg, alu_op, jump, branch,
                    mem_read, mem_write, alu_src, reg_write, sign_or_zero, illegal_op};

  int   n_chk = 0;
  int   n_pass = 0;
  ctl_t last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.sign_or_zero = 1'b1;
    return c;
  endfunction

  // Reference model: an instruction is a route of phases; waits count cycles spent in a phase.
  int         m_ph;
  logic [2:0] m_op;
  int         m_wait;
  bit         m_to;
  int         m_route[$];
  int         m_instr;
  int         m_cycles;

  task automatic model_reset();
    m_ph = PH_F; m_op = 3'd0; m_wait = 0; m_to = 1'b0;
    m_route.delete(); m_instr = 0; m_cycles = 0;
  endtask

  function automatic ctl_t model_ctl(input logic [OPW-1:0] opc, input logic ir);
    ctl_t c = idle();
    case (m_ph)
      PH_F: begin
        c.imem_req = 1'b1;
        if (ir) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      end
      PH_D: begin
        if (opc[5:3] != 3'd0) c.illegal_op = 1'b1;
        else if (opc[2:0] == 3'd2) begin c.jump = 1'b1; c.pc_write = 1'b1; end
        else if (opc[2:0] == 3'd3) begin
          c.jump = 1'b1; c.pc_write = 1'b1; c.reg_write = 1'b1;
          c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
      end
      PH_E: begin
        case (m_op)
          3'd1: begin c.alu_op = 2'b10; c.alu_src = 1'b1; c.sign_or_zero = 1'b0; end
          3'd4, 3'd5, 3'd7: begin c.alu_op = 2'b11; c.alu_src = 1'b1; end
          3'd6: begin c.alu_op = 2'b01; c.branch = 1'b1; end
          default: ;
        endcase
      end
      PH_M: begin
        if (m_op == 3'd5) c.mem_write = 1'b1;
        else              c.mem_read  = 1'b1;
      end
      PH_W: begin
        c.reg_write = 1'b1;
        if (m_op == 3'd0) c.reg_dst = 2'b01;
        if (m_op == 3'd4) c.mem_to_reg = 2'b01;
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_step(input logic [OPW-1:0] opc, input logic ir, input logic dr);
    bit bad = 1'b0;
    m_cycles++;
    if ((m_ph == PH_F && !ir) || (m_ph == PH_M && !dr)) begin
      m_wait++;
      if (m_wait >= WMAX) begin
        m_to = 1'b1; m_route.delete(); m_ph = PH_F; m_wait = 0;
      end
      return;
    end
    m_wait = 0;
    if (m_ph == PH_F) begin
      m_route.push_back(PH_D);
    end else if (m_ph == PH_D) begin
      m_op = opc[2:0];
      if (opc[5:3] != 3'd0) bad = 1'b1;
      else begin
        case (opc[2:0])
          3'd2, 3'd3: ;
          3'd6: m_route.push_back(PH_E);
          3'd4: begin m_route.push_back(PH_E); m_route.push_back(PH_M); m_route.push_back(PH_W); end
          3'd5: begin m_route.push_back(PH_E); m_route.push_back(PH_M); end
          default: begin m_route.push_back(PH_E); m_route.push_back(PH_W); end
        endcase
      end
    end
    if (m_route.size() == 0) begin
      m_ph = PH_F;
      if (!bad) m_instr++;
    end else begin
      m_ph = m_route.pop_front();
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input logic [OPW-1:0] opc, input logic ir, input logic dr, input string tag);
    opcode = opc; imem_ready = ir; dmem_ready = dr;
    #1;
    last = dut_ctl;
    chk({tag, " ctl"}, dut_ctl, model_ctl(opc, ir));
    chk({tag, " in_fetch"}, (state == 3'd0), (m_ph == PH_F));
    chk({tag, " mem_timeout"}, mem_timeout, m_to);
`ifdef CTRL_PERF_CNT_EN
    chk({tag, " cycle_cnt"}, cycle_cnt, 32'(m_cycles));
    chk({tag, " instr_cnt"}, instr_cnt, 32'(m_instr));
`endif
    model_step(opc, ir, dr);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, " rst ctl"}, dut_ctl, idle());
    chk({tag, " rst state"}, state, 3'd0);
    chk({tag, " rst timeout"}, mem_timeout, 1'b0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    chk({tag, " rst hold"}, dut_ctl, idle());
`ifdef CTRL_PERF_CNT_EN
    chk({tag, " rst counters"}, {cycle_cnt, instr_cnt}, 64'd0);
`endif
    imem_ready = 1'b0; dmem_ready = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic add_vec(inout vec_t t[$], input logic [OPW-1:0] o, input logic ir,
                         input logic dr, input ctl_t e, input bit f);
    vec_t v;
    v.opc = o; v.ir = ir; v.dr = dr; v.exp = e; v.fetch = f;
    t.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    ctl_t e, fr, wb;
    int   nmr;
    bit   irw;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] ic0, cc0;
`endif

    // Directed table from reset: addi, jal, beq, sli, R, sw, j, illegal, lw, then an idle fetch.
    fr = idle(); fr.imem_req = 1'b1; fr.ir_write = 1'b1; fr.pc_write = 1'b1;
    add_vec(tbl, 6'd7, 1, 0, fr, 1); add_vec(tbl, 6'd7, 0, 0, idle(), 0);
    e = idle(); e.alu_op = 2'b11; e.alu_src = 1'b1; add_vec(tbl, 6'd7, 0, 0, e, 0);
    e = idle(); e.reg_write = 1'b1; add_vec(tbl, 6'd7, 0, 0, e, 0);
    add_vec(tbl, 6'd3, 1, 0, fr, 1);
    e = idle(); e.jump = 1'b1; e.pc_write = 1'b1; e.reg_write = 1'b1;
    e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; add_vec(tbl, 6'd3, 0, 0, e, 0);
    add_vec(tbl, 6'd6, 1, 0, fr, 1); add_vec(tbl, 6'd6, 0, 0, idle(), 0);
    e = idle(); e.alu_op = 2'b01; e.branch = 1'b1; add_vec(tbl, 6'd6, 0, 0, e, 0);
    add_vec(tbl, 6'd1, 1, 0, fr, 1); add_vec(tbl, 6'd1, 0, 0, idle(), 0);
    e = idle(); e.alu_op = 2'b10; e.alu_src = 1'b1; e.sign_or_zero = 1'b0;
    add_vec(tbl, 6'd1, 0, 0, e, 0);
    e = idle(); e.reg_write = 1'b1; add_vec(tbl, 6'd1, 0, 0, e, 0);
    add_vec(tbl, 6'd0, 1, 0, fr, 1); add_vec(tbl, 6'd0, 0, 0, idle(), 0);
    add_vec(tbl, 6'd0, 0, 0, idle(), 0);
    e = idle(); e.reg_write = 1'b1; e.reg_dst = 2'b01; add_vec(tbl, 6'd0, 0, 0, e, 0);
    add_vec(tbl, 6'd5, 1, 0, fr, 1); add_vec(tbl, 6'd5, 0, 0, idle(), 0);
    e = idle(); e.alu_op = 2'b11; e.alu_src = 1'b1; add_vec(tbl, 6'd5, 0, 0, e, 0);
    e = idle(); e.mem_write = 1'b1; add_vec(tbl, 6'd5, 0, 1, e, 0);
    add_vec(tbl, 6'd2, 1, 0, fr, 1);
    e = idle(); e.jump = 1'b1; e.pc_write = 1'b1; add_vec(tbl, 6'd2, 0, 0, e, 0);
    add_vec(tbl, 6'b001000, 1, 0, fr, 1);
    e = idle(); e.illegal_op = 1'b1; add_vec(tbl, 6'b001000, 0, 0, e, 0);
    add_vec(tbl, 6'd4, 1, 0, fr, 1); add_vec(tbl, 6'd4, 0, 0, idle(), 0);
    e = idle(); e.alu_op = 2'b11; e.alu_src = 1'b1; add_vec(tbl, 6'd4, 0, 0, e, 0);
    e = idle(); e.mem_read = 1'b1; add_vec(tbl, 6'd4, 0, 1, e, 0);
    e = idle(); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; add_vec(tbl, 6'd4, 0, 0, e, 0);
    e = idle(); e.imem_req = 1'b1; add_vec(tbl, 6'd0, 0, 0, e, 1);

    @(negedge clk);
    do_reset("init");
    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].opc; imem_ready = tbl[i].ir; dmem_ready = tbl[i].dr;
      #1;
      chk($sformatf("vec%0d ctl", i), dut_ctl, tbl[i].exp);
      chk($sformatf("vec%0d in_fetch", i), (state == 3'd0), tbl[i].fetch);
      @(negedge clk);
    end

    // Reset in the middle of a sw memory wait drops mem_write at once.
    do_reset("t1");
    cyc(6'd5, 1, 0, "t1 F"); cyc(6'd5, 0, 0, "t1 D"); cyc(6'd5, 0, 0, "t1 E");
    cyc(6'd5, 0, 0, "t1 M");
    reset = 1'b1;
    #1;
    chk("t1 mem_write on reset", mem_write, 1'b0);
    chk("t1 sign_or_zero on reset", sign_or_zero, 1'b1);
    do_reset("t1");
    chk("t1 state after release", state, 3'd0);

    // lw with dmem_ready on the 4th MEM cycle (the expiry cycle): completes in 8 cycles.
    do_reset("t3");
    nmr = 0; wb = idle();
    for (int k = 0; k < 8; k++) begin
      cyc(6'd4, (k == 0), (k == 6), "t3");
      if (last.mem_read) nmr++;
      if (k == 7) wb = last;
    end
    chk("t3 mem_read cycles", nmr, 4);
    chk("t3 wb mem_to_reg", wb.mem_to_reg, 2'b01);
    chk("t3 back in fetch", state, 3'd0);
    chk("t3 no timeout", mem_timeout, 1'b0);

    // Instruction memory never ready: timeout after WAIT_MAX fetch cycles, no IR load.
    do_reset("t5");
    irw = 1'b0;
    for (int k = 0; k < WMAX; k++) begin
      cyc(6'd0, 0, 0, "t5");
      irw |= last.ir_write;
    end
    chk("t5 mem_timeout set", mem_timeout, 1'b1);
    chk("t5 ir_write never", irw, 1'b0);
    chk("t5 still fetching", imem_req, 1'b1);
    cyc(6'd2, 1, 0, "t5 F"); cyc(6'd2, 0, 0, "t5 D");
    chk("t5 timeout sticky", mem_timeout, 1'b1);

    // Illegal opcode: one pulse, no writes, not counted as an instruction.
    do_reset("t6");
    cyc(6'b001000, 1, 0, "t6 F");
`ifdef CTRL_PERF_CNT_EN
    ic0 = instr_cnt; cc0 = cycle_cnt;
`endif
    cyc(6'b001000, 0, 0, "t6 D");
    chk("t6 illegal pulse", last.illegal_op, 1'b1);
    chk("t6 no writes", {last.reg_write, last.pc_write, last.jump}, 3'b000);
    cyc(6'b001000, 0, 0, "t6 F2");
    chk("t6 pulse ends", last.illegal_op, 1'b0);
`ifdef CTRL_PERF_CNT_EN
    chk("t6 instr_cnt unchanged", instr_cnt, ic0);
    chk("t6 cycle_cnt advanced", cycle_cnt, cc0 + 32'd2);
`endif

    // Randomized traffic against the reference model, with occasional resets.
    do_reset("rnd");
    for (int n = 0; n < 4000; n++) begin
      logic [2:0] hi, lo;
      hi = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      lo = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset("rnd");
      cyc({hi, lo}, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
